// File: rtl/alu_serial_ctrl.sv
// Purpose : bit-serial W-bit ALU sequencer driving one shared 1-bit slice, LSB first.
// Latency : accept at edge E0, result/cout/err/done valid after edge E0+W; MUL/DIV flagged right after accept.
// Backpr. : start honoured only while busy=0; requests during RUN/DONE are dropped, never queued.
//
// Ports: clk/rst (async active-high); start/op/opa/opb request; busy/done/result/cout/err status;
//        alu_a/alu_b/alu_cin/alu_sel drive the slice, alu_result/alu_cout return from it.
module alu_serial_ctrl #(
    parameter int W  = 16,
    parameter int IW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [W-1:0]  opa,
    input  logic [W-1:0]  opb,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          cout,
    output logic          err,
    output logic          alu_a,
    output logic          alu_b,
    output logic          alu_cin,
    output logic [2:0]    alu_sel,
    input  logic          alu_result,
    input  logic          alu_cout
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic [W-1:0]   opa_q, opa_d;
    logic [W-1:0]   opb_q, opb_d;
    logic [2:0]     op_q, op_d;
    logic [W-1:0]   sh_q, sh_d;
    logic [W-1:0]   result_q, result_d;
    logic           cout_q, cout_d;
    logic           err_q, err_d;
    logic [W-1:0]   word;
    logic           is_arith;

    // ADD (000) and SUB (001) chain the carry; 1xx ops are pure bitwise.
    assign is_arith = (op_q[2:1] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            sh_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        op_d     = op_q;
        sh_d     = sh_q;
        result_d = result_q;
        cout_d   = cout_q;
        err_d    = err_q;
        alu_a    = 1'b0;
        alu_b    = 1'b0;
        alu_cin  = 1'b0;
        alu_sel  = op_q;
        word     = sh_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    opa_d = opa;
                    opb_d = opb;
                    op_d  = op;
                    idx_d = '0;
                    if (op == 3'b010 || op == 3'b011) begin
                        // No serial algorithm for MUL/DIV: report immediately.
                        state_d  = ST_DONE;
                        result_d = '0;
                        cout_d   = 1'b0;
                        err_d    = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        // SUB is a + ~b + 1: the +1 enters as the initial carry.
                        carry_d = (op == 3'b001);
                    end
                end
            end

            ST_RUN: begin
                alu_a   = opa_q[idx_q];
                alu_b   = opb_q[idx_q];
                alu_cin = is_arith ? carry_q : 1'b0;
                // Merge the current slice bit so the final edge captures the whole word.
                word[idx_q] = alu_result;
                sh_d        = word;
                if (is_arith) begin
                    carry_d = alu_cout;
                end
                if (idx_q == LAST_IDX) begin
                    result_d = word;
                    cout_d   = is_arith ? alu_cout : 1'b0;
                    err_d    = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign err    = err_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
module tb_alu_serial_ctrl;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          cout;
    logic          err;
    logic          alu_a;
    logic          alu_b;
    logic          alu_cin;
    logic [2:0]    alu_sel;
    logic          alu_result;
    logic          alu_cout;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0]  last_res  = '0;
    logic          last_cout = 1'b0;
    logic          last_err  = 1'b0;

    alu_serial_ctrl #(.W(W), .IW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .opa        (opa),
        .opb        (opb),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cout       (cout),
        .err        (err),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cin    (alu_cin),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    always #5 clk = ~clk;

    // Behavioural 1-bit slice.
    logic b_eff;
    always_comb begin
        b_eff = (alu_sel == 3'b001) ? ~alu_b : alu_b;
        alu_cout = (alu_a & b_eff) | (alu_a & alu_cin) | (b_eff & alu_cin);
        case (alu_sel)
            3'b100:  alu_result = alu_a & alu_b;
            3'b101:  alu_result = alu_a | alu_b;
            3'b110:  alu_result = alu_a ^ alu_b;
            3'b111:  alu_result = ~(alu_a ^ alu_b);
            default: alu_result = alu_a ^ b_eff ^ alu_cin;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Word-level reference: plain arithmetic on whole operands.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic c, output logic e);
        logic [W:0] s;
        r = '0; c = 1'b0; e = 1'b0;
        case (o)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; end
            3'b001: begin r = a - b; c = (a >= b); end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            3'b111: r = ~(a ^ b);
            default: e = 1'b1;
        endcase
    endtask

    // inj: 0 none, 1 start pulse during RUN, 2 start pulse during DONE
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj);
        logic [W-1:0] er;
        logic         ec, ee;
        int           n;
        bit           unsup;
        model(o, a, b, er, ec, ee);
        unsup = (o == 3'b010 || o == 3'b011);
        @(negedge clk);
        start = 1'b1; op = o; opa = a; opb = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op  = 3'($urandom);
        opa = W'($urandom);
        opb = W'($urandom);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (inj == 1 && n == 4) start = 1'b0;
            if (done) break;
            if (n > W + 4) begin
                chk("done_timeout", n, W + 1);
                break;
            end
            chk("run_busy", busy, 1);
            chk("run_result_held", result, last_res);
            chk("run_cout_held", cout, last_cout);
            if (o[2]) chk("logic_cin", alu_cin, 0);
            if (o == 3'b001 && n == 1) chk("sub_cin_bit0", alu_cin, 1);
            if (inj == 1 && n == 3) begin
                start = 1'b1; op = 3'b000; opa = W'($urandom); opb = W'($urandom);
            end
        end
        start = 1'b0;
        chk("latency", n - 1, unsup ? 0 : W);
        chk("result", result, er);
        chk("cout", cout, ec);
        chk("err", err, ee);
        chk("done_busy", busy, 1);
        if (unsup) begin
            chk("unsup_alu_a", alu_a, 0);
            chk("unsup_alu_b", alu_b, 0);
        end
        if (inj == 2) begin
            start = 1'b1; op = 3'b000; opa = W'($urandom); opb = W'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse_width", done, 0);
        chk("busy_fall", busy, 0);
        chk("result_kept", result, er);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_alu_a", alu_a, 0);
        last_res = er; last_cout = ec; last_err = ee;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; opa = '0; opb = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_cout", cout, 0);
        chk("rst_err", err, 0);
        chk("rst_alu_cin", alu_cin, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(3'b000, 16'h1234, 16'h4321, 0);
        do_op(3'b000, 16'hFFFF, 16'h0001, 0);
        do_op(3'b001, 16'h0005, 16'h0003, 0);
        do_op(3'b001, 16'h0003, 16'h0005, 0);
        do_op(3'b110, 16'hAAAA, 16'hFFFF, 0);
        do_op(3'b111, 16'h00FF, 16'h0F0F, 0);
        do_op(3'b100, 16'hF0F0, 16'hFF00, 1);
        do_op(3'b101, 16'h0001, 16'h8000, 2);
        do_op(3'b010, 16'h1357, 16'hFFFF, 0);
        do_op(3'b011, 16'hFFFF, 16'h2468, 2);

        // Reset in the middle of an ADD, on the bit-7 cycle.
        @(negedge clk);
        start = 1'b1; op = 3'b000; opa = 16'h7777; opb = 16'h1111;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_result", result, 0);
        chk("midrst_alu_a", alu_a, 0);
        #1;
        rst = 1'b0;
        last_res = '0; last_cout = 1'b0; last_err = 1'b0;
        @(negedge clk);
        chk("postrst_done", done, 0);
        do_op(3'b000, 16'h0002, 16'h0003, 0);

        for (int i = 0; i < 24; i++) begin
            do_op(3'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
